mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Target-side (responder) end of the shared memory interconnect that the data and instruction caches initiate on.
- Each request carries one 32-bit word. The block:
  - samples the bus request;
  - waits a programmable access latency;
  - then either returns a read word, or commits a sized, byte-offset write into a word-organised backing store.
- Acknowledges every transfer with a one-cycle mem_data_valid pulse.

Parameters:
- LATENCY, 4: cycles from request acceptance to mem_data_valid; legal range 1..15.
- ADDR_BITS, 10: word-index width; backing store holds 2^ADDR_BITS 32-bit words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_en  in  1  bus owned by some initiator; its address and control are valid.
- mem_req  in  1  request strobe from the bus owner.
- mem_rd_wr  in  1  0 = read, 1 = write.
- mem_addr  in  32  byte address.
- mem_wr_size  in  2  write byte count: 01 = 1, 10 = 2, 11 = 3, 00 = 4.
- mem_data_in  in  32  write data, least-significant-byte aligned; unused upper bytes are zero.
- mem_data_out  out  32  read data.
- mem_data_oe  out  1  drive enable for mem_data_out onto the shared tristate data bus.
- mem_data_valid  out  1  one-cycle completion pulse.
- busy  out  1  transfer in flight; high whenever state is not IDLE.
- protocol_err  out  1  sticky flag: a write ran past a word boundary.

Behaviour:
- Reset values: mem_data_out = 0, mem_data_oe = 0, mem_data_valid = 0, busy = 0, protocol_err = 0, state = IDLE, counter = 0.
- Reset does not clear the backing store.
- Reset asserted mid-transfer aborts the transfer; no memory write occurs.
- States: IDLE, WAIT, RESP.
- IDLE -> WAIT (or -> RESP when LATENCY = 1):
  - Occurs on the edge where mem_en & mem_req = 1.
  - At that edge, latch mem_rd_wr, mem_addr, mem_wr_size and mem_data_in into request registers.
  - Load counter = LATENCY-1.
- WAIT:
  - Decrement the counter every cycle.
  - Go to RESP on the edge where the counter = 1.
  - mem_data_valid is high exactly LATENCY cycles after the accept edge.
- RESP (exactly one cycle):
  - mem_data_valid = 1.
  - Read: mem_data_out = mem[addr[ADDR_BITS+1:2]] and mem_data_oe = 1; addr[1:0] is ignored because reads are word-aligned.
  - Write: mem_data_oe = 0. On the edge leaving RESP, write byte lanes off..off+n-1, where off = addr[1:0] and n = decoded size.
  - Lane k takes mem_data_in byte (k-off).
  - Mask rule:
    - If off + n > 4, write only lanes off..3.
    - Set protocol_err; it stays set until reset.
  - Unconditionally go to IDLE.
- Ignored during WAIT/RESP: mem_req, mem_en and all request fields. The request registers are frozen.
- Outside RESP: mem_data_oe = 0 and mem_data_out = 0.
- Back-to-back requests: mem_req high in the first IDLE cycle after RESP is a new request. Initiators must drop mem_req in the cycle after mem_data_valid.
- Read-after-write ordering: a read accepted after a write's RESP sees the written data, because the write commits at the RESP exit edge, before any later accept.
- Address wrap: address bits above ADDR_BITS+1 are ignored, so the index wraps modulo 2^ADDR_BITS.
- Counter width is 4 bits; LATENCY = 1 bypasses WAIT entirely.
- mem_req without mem_en is never accepted.

Test Plan:
1. Basic write then read:
   - LATENCY=4. Write addr 0x40, size 00, data 0xDEADBEEF; then read 0x40.
   - Each transfer gives mem_data_valid 4 cycles after its accept edge.
   - The read returns 0xDEADBEEF with mem_data_oe = 1 for exactly one cycle.
2. Sized write into an existing word:
   - Preload 0x11223344 at 0x80. Write addr 0x81, size 10, data 0x0000AABB.
   - Reading 0x80 returns 0x11AABB44; protocol_err stays 0.
3. Boundary overrun:
   - Write addr 0x103, size 11, data 0x00CCBBAA onto word 0.
   - Reading 0x100 returns 0xAA000000 and protocol_err = 1.
   - protocol_err stays 1 until reset.
4. Requests while busy:
   - Toggle mem_req and change mem_addr during WAIT.
   - Exactly one mem_data_valid, for the originally latched address.
   - busy stays high from the accept edge through RESP.
5. Reset mid-transfer:
   - Assert reset two cycles into a write to 0x20.
   - All outputs go to 0 immediately, with no clock edge needed.
   - A later read of 0x20 returns its old value.
6. LATENCY=1 back-to-back:
   - Issue two reads on consecutive accept opportunities.
   - mem_data_valid arrives in the cycle after each accept.
   - Two pulses are separated by one IDLE cycle; mem_req without mem_en is ignored.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Responder end of the shared memory bus: fixed-latency read/write
// into a word-organised store with sized, byte-offset writes.
module mem_bus_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_req,
    input  logic        mem_rd_wr,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_wr_size,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        mem_data_oe,
    output logic        mem_data_valid,
    output logic        busy,
    output logic        protocol_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    state_t                 state;
    logic [3:0]             counter;
    logic                   req_rd_wr;
    logic [ADDR_BITS-1:0]   req_idx;
    logic [1:0]             req_off;
    logic [1:0]             req_size;
    logic [31:0]            req_data;

    logic [31:0]            mem [2**ADDR_BITS];

    logic [ADDR_BITS-1:0]   bus_idx;
    logic [2:0]             wr_off;
    logic [2:0]             wr_cnt;
    logic [2:0]             wr_end;
    logic [3:0]             wr_mask;
    logic [31:0]            wr_data;
    logic                   wr_overrun;

    // Address bits above the word index are deliberately dropped (wrap).
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_BITS+2];

    assign bus_idx    = mem_addr[ADDR_BITS+1:2];
    assign wr_off     = {1'b0, req_off};
    assign wr_cnt     = (req_size == 2'b00) ? 3'd4 : {1'b0, req_size};
    assign wr_end     = wr_off + wr_cnt;
    assign wr_overrun = wr_end > 3'd4;
    assign wr_data    = req_data << {req_off, 3'b000};

    // Lanes off..off+n-1, clipped at lane 3 when the write overruns.
    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < 4; k++) begin
            wr_mask[k] = (3'(k) >= wr_off) && (3'(k) < wr_end);
        end
    end

    // Commit the latched write on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (state == RESP && req_rd_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask[k]) begin
                    mem[req_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Request sequencing with registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            req_rd_wr      <= 1'b0;
            req_idx        <= '0;
            req_off        <= '0;
            req_size       <= '0;
            req_data       <= '0;
            mem_data_out   <= '0;
            mem_data_oe    <= 1'b0;
            mem_data_valid <= 1'b0;
            busy           <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            mem_data_out   <= '0;
            mem_data_oe    <= 1'b0;
            mem_data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_en && mem_req) begin
                        req_rd_wr <= mem_rd_wr;
                        req_idx   <= bus_idx;
                        req_off   <= mem_addr[1:0];
                        req_size  <= mem_wr_size;
                        req_data  <= mem_data_in;
                        counter   <= LOAD;
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state          <= RESP;
                            mem_data_valid <= 1'b1;
                            mem_data_oe    <= !mem_rd_wr;
                            mem_data_out   <= mem_rd_wr ? '0 : mem[bus_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    counter <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        state          <= RESP;
                        mem_data_valid <= 1'b1;
                        mem_data_oe    <= !req_rd_wr;
                        mem_data_out   <= req_rd_wr ? '0 : mem[req_idx];
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (req_rd_wr && wr_overrun) begin
                        protocol_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: a LATENCY=4 instance and a
// LATENCY=1 instance share the bus; sel picks which one owns mem_en.
module tb_mem_bus_responder;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        oe;
        bit          busy_ok;
        bit          quiet_ok;
        logic        after_valid;
        logic        after_oe;
        logic        after_busy;
        logic [31:0] after_dout;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        en;
    logic        req;
    logic        rd_wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] din;

    logic        en0, en1;
    logic [31:0] dout0, dout1, dout;
    logic        oe0, oe1, oe;
    logic        v0, v1, valid;
    logic        b0, b1, busy;
    logic        pe0, pe1, perr;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][1024];
    bit          merr  [2];

    assign en0   = en & ~sel;
    assign en1   = en & sel;
    assign dout  = sel ? dout1 : dout0;
    assign oe    = sel ? oe1 : oe0;
    assign valid = sel ? v1 : v0;
    assign busy  = sel ? b1 : b0;
    assign perr  = sel ? pe1 : pe0;

    always #5 clk = ~clk;

    mem_bus_responder #(.LATENCY(4), .ADDR_BITS(10)) dut0 (
        .clk(clk), .reset(reset), .mem_en(en0), .mem_req(req),
        .mem_rd_wr(rd_wr), .mem_addr(addr), .mem_wr_size(size),
        .mem_data_in(din), .mem_data_out(dout0), .mem_data_oe(oe0),
        .mem_data_valid(v0), .busy(b0), .protocol_err(pe0)
    );

    mem_bus_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
        .clk(clk), .reset(reset), .mem_en(en1), .mem_req(req),
        .mem_rd_wr(rd_wr), .mem_addr(addr), .mem_wr_size(size),
        .mem_data_in(din), .mem_data_out(dout1), .mem_data_oe(oe1),
        .mem_data_valid(v1), .busy(b1), .protocol_err(pe1)
    );

    // Reference write: n bytes from data land at lanes off.., lanes past 3 lost.
    function automatic void model_write(int d, logic [31:0] a,
                                        logic [1:0] s, logic [31:0] data);
        int off = int'(a[1:0]);
        int n   = (s == 2'b00) ? 4 : int'(s);
        int idx = int'(a[11:2]);
        for (int i = 0; i < n; i++) begin
            if (off + i < 4) model[d][idx][8*(off+i) +: 8] = data[8*i +: 8];
        end
        if (off + n > 4) merr[d] = 1'b1;
    endfunction

    // One bus transfer, starting on a negedge while the responder is idle.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d,
                        input bit noisy, output xfer_t o);
        o.lat = 0; o.rdata = '0; o.oe = 1'b0;
        o.busy_ok = 1'b1; o.quiet_ok = 1'b1;
        en = 1'b1; req = 1'b1; rd_wr = w; addr = a; size = s; din = d;
        @(posedge clk);
        #1;
        en = 1'b0; req = 1'b0;
        rd_wr = 1'($urandom); addr = $urandom;
        size = 2'($urandom); din = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!busy) o.busy_ok = 1'b0;
            if (valid) begin
                o.lat = k; o.rdata = dout; o.oe = oe;
                en = 1'b0; req = 1'b0;
                break;
            end
            if (oe || dout != 32'h0) o.quiet_ok = 1'b0;
            if (noisy) begin
                en = 1'($urandom); req = 1'($urandom);
                rd_wr = 1'($urandom); addr = $urandom;
                size = 2'($urandom); din = $urandom;
            end
        end
        @(negedge clk);
        o.after_valid = valid; o.after_oe = oe;
        o.after_busy = busy; o.after_dout = dout;
        if (w) model_write(sel ? 1 : 0, a, s, d);
    endtask

    task automatic test_reset();
        sel = 1'b0; en = 1'b0; req = 1'b0; rd_wr = 1'b0;
        addr = '0; size = '0; din = '0;
        merr[0] = 1'b0; merr[1] = 1'b0;
        reset = 1'b1;
        #3;
        checks++;
        if ({dout0, oe0, v0, b0, pe0} !== 36'h0) begin
            errors++;
            $display("FAIL reset_dut0: got %h expected 0", {dout0, oe0, v0, b0, pe0});
        end
        checks++;
        if ({dout1, oe1, v1, b1, pe1} !== 36'h0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {dout1, oe1, v1, b1, pe1});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        xfer_t o;
        sel = 1'b0;
        xfer(1'b1, 32'h40, 2'b00, 32'hDEADBEEF, 1'b0, o);
        checks++;
        if (o.lat !== 4 || o.oe !== 1'b0) begin
            errors++;
            $display("FAIL basic_wr: lat %0d oe %b expected lat 4 oe 0", o.lat, o.oe);
        end
        xfer(1'b0, 32'h40, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.lat !== 4) begin
            errors++;
            $display("FAIL basic_rd_lat: got %0d expected 4", o.lat);
        end
        checks++;
        if (o.rdata !== 32'hDEADBEEF || o.oe !== 1'b1) begin
            errors++;
            $display("FAIL basic_rd_data: got %h oe %b expected deadbeef oe 1", o.rdata, o.oe);
        end
        checks++;
        if ({o.after_valid, o.after_oe, o.after_busy} !== 3'b000 ||
            o.after_dout !== 32'h0 || !o.busy_ok || !o.quiet_ok) begin
            errors++;
            $display("FAIL basic_one_cycle: after v/oe/busy %b%b%b dout %h busy_ok %0d quiet_ok %0d expected 000 0 1 1",
                     o.after_valid, o.after_oe, o.after_busy, o.after_dout, o.busy_ok, o.quiet_ok);
        end
    endtask

    task automatic test_sized();
        xfer_t o;
        sel = 1'b0;
        xfer(1'b1, 32'h80, 2'b00, 32'h11223344, 1'b0, o);
        xfer(1'b1, 32'h81, 2'b10, 32'h0000AABB, 1'b0, o);
        xfer(1'b0, 32'h80, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== 32'h11AABB44) begin
            errors++;
            $display("FAIL sized_rd: got %h expected 11aabb44", o.rdata);
        end
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL sized_perr: got %b expected 0", perr);
        end
    endtask

    task automatic test_overrun();
        xfer_t o;
        sel = 1'b0;
        xfer(1'b1, 32'h100, 2'b00, 32'h0, 1'b0, o);
        xfer(1'b1, 32'h103, 2'b11, 32'h00CCBBAA, 1'b0, o);
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_perr: got %b expected 1", perr);
        end
        xfer(1'b0, 32'h100, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== 32'hAA000000) begin
            errors++;
            $display("FAIL overrun_rd: got %h expected aa000000", o.rdata);
        end
        xfer(1'b1, 32'h104, 2'b01, 32'h5A, 1'b0, o);
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 1", perr);
        end
    endtask

    task automatic test_busy_noise();
        xfer_t o;
        logic [31:0] d;
        sel = 1'b0;
        xfer(1'b0, 32'h40, 2'b00, 32'h0, 1'b1, o);
        checks++;
        if (o.lat !== 4 || o.rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL noise_rd: lat %0d data %h expected lat 4 data deadbeef", o.lat, o.rdata);
        end
        checks++;
        if (!o.busy_ok || o.after_valid !== 1'b0 || o.after_busy !== 1'b0) begin
            errors++;
            $display("FAIL noise_busy: busy_ok %0d after_valid %b after_busy %b expected 1 0 0",
                     o.busy_ok, o.after_valid, o.after_busy);
        end
        d = $urandom;
        xfer(1'b1, 32'h44, 2'b00, d, 1'b1, o);
        xfer(1'b0, 32'h44, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== model[0][17]) begin
            errors++;
            $display("FAIL noise_wr: got %h expected %h", o.rdata, model[0][17]);
        end
    endtask

    task automatic test_reset_mid();
        xfer_t o;
        sel = 1'b0;
        xfer(1'b1, 32'h20, 2'b00, 32'h5555AAAA, 1'b0, o);
        en = 1'b1; req = 1'b1; rd_wr = 1'b1; addr = 32'h20;
        size = 2'b00; din = 32'h12345678;
        @(posedge clk);
        #1;
        en = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({dout0, oe0, v0, b0, pe0} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {dout0, oe0, v0, b0, pe0});
        end
        merr[0] = 1'b0; merr[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        xfer(1'b0, 32'h20, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.rdata !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL reset_mid_rd: got %h expected 5555aaaa", o.rdata);
        end
    endtask

    task automatic test_random();
        xfer_t o;
        int idx [8];
        logic [31:0] a, d, exp;
        logic [1:0] s;
        int n, pick;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx[i] = $urandom_range(0, 1023);
            xfer(1'b1, 32'(idx[i]) << 2, 2'b00, $urandom, 1'b0, o);
        end
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 7);
            a = ($urandom & 32'hFFFFF000) | (32'(idx[pick]) << 2) | 32'($urandom_range(0, 3));
            s = 2'($urandom);
            n = (s == 2'b00) ? 4 : int'(s);
            d = (n == 4) ? $urandom : ($urandom & ((32'h1 << (8*n)) - 32'h1));
            if ($urandom_range(0, 1) == 1) begin
                xfer(1'b1, a, s, d, 1'($urandom), o);
            end else begin
                exp = model[0][idx[pick]];
                xfer(1'b0, a, s, d, 1'($urandom), o);
                checks++;
                if (o.rdata !== exp || o.oe !== 1'b1 || o.lat !== 4) begin
                    errors++;
                    $display("FAIL rand_rd[%0d]: addr %h data %h oe %b lat %0d expected %h 1 4",
                             t, a, o.rdata, o.oe, o.lat, exp);
                end
            end
            checks++;
            if (perr !== merr[0]) begin
                errors++;
                $display("FAIL rand_perr[%0d]: got %b expected %b", t, perr, merr[0]);
            end
        end
    endtask

    task automatic test_latency1();
        xfer_t o;
        logic [31:0] da, db;
        sel = 1'b1;
        en = 1'b0; req = 1'b1; rd_wr = 1'b0; addr = 32'h30;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL l1_no_en: busy %b valid %b expected 0 0", busy, valid);
            end
        end
        req = 1'b0;
        da = $urandom; db = $urandom;
        xfer(1'b1, 32'h30, 2'b00, da, 1'b0, o);
        checks++;
        if (o.lat !== 1) begin
            errors++;
            $display("FAIL l1_wr_lat: got %0d expected 1", o.lat);
        end
        xfer(1'b1, 32'h34, 2'b00, db, 1'b0, o);
        xfer(1'b0, 32'h30, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.lat !== 1 || o.rdata !== model[1][12] || o.after_valid !== 1'b0) begin
            errors++;
            $display("FAIL l1_rd_a: lat %0d data %h after_valid %b expected 1 %h 0",
                     o.lat, o.rdata, o.after_valid, model[1][12]);
        end
        xfer(1'b0, 32'h34, 2'b00, 32'h0, 1'b0, o);
        checks++;
        if (o.lat !== 1 || o.rdata !== model[1][13] || o.oe !== 1'b1) begin
            errors++;
            $display("FAIL l1_rd_b: lat %0d data %h oe %b expected 1 %h 1",
                     o.lat, o.rdata, o.oe, model[1][13]);
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_sized();
        test_overrun();
        test_busy_noise();
        test_reset_mid();
        test_random();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
